// File: rtl/truth_table_scanner.sv
// Drives all eight {x,y,z} minterms, samples F1..F4 and checks them against expected tables.
// Defining TT_ERR_LOG_EN adds err_valid/err_idx/err_func, which log the first failing pair.
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  EXP_F1     = 8'hBE,
  parameter logic [7:0]  EXP_F2     = 8'hBE,
  parameter logic [7:0]  EXP_F3     = 8'hBE,
  parameter logic [7:0]  EXP_F4     = 8'hBE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] f_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [7:0] f1_tt,
  output logic [7:0] f2_tt,
  output logic [7:0] f3_tt,
  output logic [7:0] f4_tt
`ifdef TT_ERR_LOG_EN
  ,
  output logic       err_valid,
  output logic [2:0] err_idx,
  output logic [1:0] err_func
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0][7:0] tt_q, tt_d;
  logic [3:0]      mis_q, mis_d;
  logic            pass_q, pass_d;
  logic [3:0][7:0] exp_tt;

  assign exp_tt = {EXP_F4, EXP_F3, EXP_F2, EXP_F1};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          tt_d    = '0;
          mis_d   = 4'd0;
          pass_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        for (int k = 0; k < 4; k++) tt_d[k][idx_q] = f_in[k];
        if (idx_q == 3'd7) begin
          // Verdict is formed from the completed tables so it is valid with done
          for (int k = 0; k < 4; k++) mis_d[k] = (tt_d[k] != exp_tt[k]);
          pass_d  = ~|mis_d;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      tt_q    <= '0;
      mis_q   <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

  assign {x, y, z} = idx_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign mismatch  = mis_q;
  assign f1_tt     = tt_q[0];
  assign f2_tt     = tt_q[1];
  assign f3_tt     = tt_q[2];
  assign f4_tt     = tt_q[3];

`ifdef TT_ERR_LOG_EN
  logic       errv_q, errv_d;
  logic [2:0] erri_q, erri_d;
  logic [1:0] errf_q, errf_d;

  always_comb begin
    errv_d = errv_q;
    erri_d = erri_q;
    errf_d = errf_q;
    if (state_q == S_IDLE && start) begin
      errv_d = 1'b0;
      erri_d = 3'd0;
      errf_d = 2'd0;
    end else if (state_q == S_SAMPLE && !errv_q) begin
      // Walk downwards so the lowest failing function is the one kept
      for (int k = 3; k >= 0; k--) begin
        if (f_in[k] != exp_tt[k][idx_q]) begin
          errv_d = 1'b1;
          erri_d = idx_q;
          errf_d = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errv_q <= 1'b0;
      erri_q <= 3'd0;
      errf_q <= 2'd0;
    end else begin
      errv_q <= errv_d;
      erri_q <= erri_d;
      errf_q <= errf_d;
    end
  end

  assign err_valid = errv_q;
  assign err_idx   = erri_q;
  assign err_func  = errf_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a reference exercise block on one instance,
// an XOR block with SETTLE_CYC=1 on a second; results checked through a scoreboard queue.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic       x0, y0, z0, busy0, done0, pass0;
  logic [3:0] mis0, f0;
  logic [7:0] a0, b0, c0, d0;
  logic       x1, y1, z1, busy1, done1, pass1;
  logic [3:0] mis1, fx;
  logic [7:0] a1, b1, c1, d1;
`ifdef TT_ERR_LOG_EN
  logic       ev0, ev1;
  logic [2:0] ei0, ei1;
  logic [1:0] ef0, ef1;
`endif

  logic [7:0] ref_tt = 8'hBE;
  logic [3:0] force_lo = 4'd0;
  logic [2:0] m0;

  assign m0 = {x0, y0, z0};
  assign f0 = {4{ref_tt[m0]}} & ~force_lo;
  assign fx = {4{x1 ^ y1 ^ z1}};

  always #5 clk = ~clk;

  truth_table_scanner u0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0),
    .pass(pass0), .mismatch(mis0),
    .f1_tt(a0), .f2_tt(b0), .f3_tt(c0), .f4_tt(d0)
`ifdef TT_ERR_LOG_EN
    , .err_valid(ev0), .err_idx(ei0), .err_func(ef0)
`endif
  );

  truth_table_scanner #(.SETTLE_CYC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(fx),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .pass(pass1), .mismatch(mis1),
    .f1_tt(a1), .f2_tt(b1), .f3_tt(c1), .f4_tt(d1)
`ifdef TT_ERR_LOG_EN
    , .err_valid(ev1), .err_idx(ei1), .err_func(ef1)
`endif
  );

  typedef struct {
    int          lat;
    logic [31:0] tts;
    logic [3:0]  mis;
    logic        pas;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int lat, input logic [31:0] tts,
                      input logic [3:0] mis, input logic pas);
    exp_t e;
    e.lat = lat;
    e.tts = tts;
    e.mis = mis;
    e.pas = pas;
    sbq.push_back(e);
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start1 = 1'b1;
    else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic score(input bit which, input int lat);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    if (which) begin
      chk("tt1", {d1, c1, b1, a1}, e.tts);
      chk("mis1", {28'd0, mis1}, {28'd0, e.mis});
      chk("pass1", {31'd0, pass1}, {31'd0, e.pas});
      chk("busy1_done", {31'd0, busy1}, 32'd0);
    end else begin
      chk("tt0", {d0, c0, b0, a0}, e.tts);
      chk("mis0", {28'd0, mis0}, {28'd0, e.mis});
      chk("pass0", {31'd0, pass0}, {31'd0, e.pas});
      chk("busy0_done", {31'd0, busy0}, 32'd0);
    end
  endtask

  // Returns at the negedge of the done cycle; k counts cycles after the start edge
  task automatic run_wait(input bit which, input int spv, input bit stim,
                          input bit poke);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (poke && k == 5) start0 = 1'b1;
      if (poke && k == 6) start0 = 1'b0;
      if (stim && k < 8 * spv) begin
        chk("stim_xyz", {29'd0, x0, y0, z0}, 32'(k / spv));
        chk("busy_hi", {31'd0, busy0}, 32'd1);
      end
      if (which ? done1 : done0) begin
        seen = 1'b1;
        score(which, k);
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
  endtask

  initial begin
    bit extra;

    repeat (2) @(negedge clk);
    chk("rst_xyz", {29'd0, x0, y0, z0}, 32'd0);
    chk("rst_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("rst_done", {30'd0, done0, done1}, 32'd0);
    chk("rst_pass", {30'd0, pass0, pass1}, 32'd0);
    chk("rst_mis", {24'd0, mis1, mis0}, 32'd0);
    chk("rst_tt", {d0, c0, b0, a0}, 32'd0);
    rst = 1'b0;

    push(24, {4{8'hBE}}, 4'b0000, 1'b1);
    pulse(1'b0);
    run_wait(1'b0, 3, 1'b1, 1'b0);
`ifdef TT_ERR_LOG_EN
    chk("err_v_ok", {31'd0, ev0}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("hold_xyz", {29'd0, x0, y0, z0}, 32'd7);
    chk("idle_busy", {31'd0, busy0}, 32'd0);
    chk("pass_held", {31'd0, pass0}, 32'd1);

    force_lo = 4'b0100;
    push(24, {8'hBE, 8'h00, 8'hBE, 8'hBE}, 4'b0100, 1'b0);
    pulse(1'b0);
    run_wait(1'b0, 3, 1'b0, 1'b0);
`ifdef TT_ERR_LOG_EN
    chk("err_v", {31'd0, ev0}, 32'd1);
    chk("err_idx", {29'd0, ei0}, 32'd1);
    chk("err_func", {30'd0, ef0}, 32'd2);
`endif
    force_lo = 4'b0000;

    push(24, {4{8'hBE}}, 4'b0000, 1'b1);
    pulse(1'b0);
    run_wait(1'b0, 3, 1'b0, 1'b1);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("poke_done_lo", {31'd0, done0}, 32'd0);
    chk("poke_busy_lo", {31'd0, busy0}, 32'd0);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(negedge clk);
    chk("restart_busy", {31'd0, busy0}, 32'd1);
    chk("restart_xyz", {29'd0, x0, y0, z0}, 32'd0);
    chk("restart_pass", {31'd0, pass0}, 32'd0);
    repeat (12) @(negedge clk);
    chk("idx4_xyz", {29'd0, x0, y0, z0}, 32'd4);
    chk("idx4_tt_part", {24'd0, a0}, 32'h0E);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_xyz", {29'd0, x0, y0, z0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_tt", {d0, c0, b0, a0}, 32'd0);
    chk("abort_pass", {31'd0, pass0}, 32'd0);
    extra = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done0) extra = 1'b1;
    end
    chk("abort_no_done", {31'd0, extra}, 32'd0);

    push(16, {4{8'h96}}, 4'b1111, 1'b0);
    pulse(1'b1);
    run_wait(1'b1, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("xor_hold_xyz", {29'd0, x1, y1, z1}, 32'd7);
    chk("xor_mis_held", {28'd0, mis1}, 32'hF);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture engine for the three-input logic exercise blocks (inputs `x`, `y`, `z`; outputs `F1`..`F4`). On a start pulse it drives all eight input combinations in minterm order, waits a programmable settle time, and samples the four function outputs into 8-bit truth tables. It then compares each table against a parameterised expected minterm mask and reports pass/fail per function. It sits on the bench/board side of the exercise block, driving its inputs and reading its outputs.

## Interface
- `SETTLE_CYC`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `EXP_F1`, default 8'hBE: expected truth table for F1; bit i is the minterm with {x,y,z}=i.
- `EXP_F2`, default 8'hBE: expected truth table for F2.
- `EXP_F3`, default 8'hBE: expected truth table for F3.
- `EXP_F4`, default 8'hBE: expected truth table for F4.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `f_in`  in  4  sampled DUT outputs {F4,F3,F2,F1}.
- `x`, `y`, `z`  out  1 each  registered stimulus; {x,y,z} = current minterm index.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when a scan completes.
- `pass`  out  1  all four tables match expected; valid from `done`, held until next accepted start.
- `mismatch`  out  4  per-function mismatch flags {F4,F3,F2,F1}; same validity as `pass`.
- `f1_tt`, `f2_tt`, `f3_tt`, `f4_tt`  out  8 each  captured truth tables.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE (one-hot or binary is an implementation choice).
- IDLE: `start`=1 → idx←0, settle counter←0, all tables←0, `pass`←0, `mismatch`←0, go to SETTLE.
- SETTLE: {x,y,z}=idx; counter increments each cycle; after SETTLE_CYC cycles in SETTLE go to SAMPLE.
- SAMPLE: bit idx of each table ← corresponding bit of `f_in`; if idx=7 → DONE, else idx←idx+1, counter←0 → SETTLE.
- DONE: `done`=1 for this one cycle; `mismatch[k]` = (fk_tt ≠ EXP_Fk); `pass` = ~|mismatch; go to IDLE.
- `start` in SETTLE, SAMPLE or DONE is ignored (no queuing).
- idx is 3 bits; it never wraps during a scan (the SAMPLE at idx=7 exits to DONE).
- Stimulus outputs hold the last driven vector (3'b111) after the scan until reset or next start.
- Reset values: state IDLE, `x`=`y`=`z`=0, `busy`=0, `done`=0, `pass`=0, `mismatch`=0, all tables 8'h00.
- Reset mid-scan aborts immediately to the reset values; no `done` is produced.

## Timing
- Each vector occupies SETTLE_CYC+1 cycles (SETTLE_CYC settle + 1 sample).
- Start accepted at edge E0 → SETTLE for idx 0 begins at E0; `done` is high in the cycle after edge E0 + 8·(SETTLE_CYC+1).
- Default SETTLE_CYC=2: `done` 24 cycles after the accepting edge. SETTLE_CYC=1: 16 cycles.
- `f_in` is sampled on the clock edge that leaves SAMPLE; DUT combinational delay must fit within SETTLE_CYC cycles.
- `busy` falls on entry to DONE; the earliest next accepted `start` is the cycle after `done`.

## Configuration
- `TT_ERR_LOG_EN` defined: adds outputs `err_valid` (1), `err_idx` (3), `err_func` (2). These record the first failing (minterm, function) pair in scan order, with the lowest function index winning within a minterm. The comparison is done at SAMPLE against the corresponding EXP bit. All three clear on reset and on an accepted start. `err_valid`=0 after a fully passing scan.
- Undefined: these ports and their logic are absent; mismatch is reported only via `mismatch`/`pass` at DONE.

## Test plan
- Correct exercise block attached, defaults → all tables 8'hBE, `mismatch`=4'b0000, `pass`=1, `done` exactly 24 cycles after the start edge.
- `f_in[2]` forced to 0 → `f3_tt`=8'h00, `mismatch`=4'b0100, `pass`=0; with TT_ERR_LOG_EN: `err_valid`=1, `err_idx`=1, `err_func`=2.
- `start` pulsed again at cycle 5 of a scan and again in the DONE cycle → both ignored, one `done` only; a `start` in the following IDLE cycle is accepted.
- `rst` asserted during idx=4 SETTLE → next cycle state IDLE, `x`,`y`,`z`=0, tables 8'h00, `busy`=0, no `done` pulse.
- SETTLE_CYC=1 with the DUT replaced by `f_in`={4{x^y^z}} → each table 8'h96, `mismatch`=4'b1111, `done` 16 cycles after start.
- Stimulus check: `{x,y,z}` steps 0→7 with each value held SETTLE_CYC+1 cycles, then holds 3'b111 in IDLE.
